// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, LSU state encoding and access-size helper
// for the mem_lsu load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int MEM_BYTES_DEF = 1024;
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;
    function automatic logic [2:0] acc_size(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 3'd1 : f3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational load extract/extend and sub-word store merge.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);
    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;
    always_comb begin
        w_sh    = {i_off, 3'b000};
        w_byte  = 8'(i_word >> w_sh);
        w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
        w_bmask = 32'h0000_00FF << w_sh;
        o_load  = i_f3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
                  i_f3 == F3_H  ? {{16{w_half[15]}}, w_half} :
                  i_f3 == F3_BU ? {24'b0, w_byte} :
                  i_f3 == F3_HU ? {16'b0, w_half} : i_word;
        o_store = i_f3[1:0] == 2'b00 ? (i_word & ~w_bmask) | ({24'b0, i_wdata[7:0]} << w_sh) :
                  i_f3[1:0] == 2'b01 ? (i_off[1] ? {i_wdata[15:0], i_word[15:0]}
                                                 : {i_word[31:16], i_wdata[15:0]}) : i_wdata;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding RV32 load/store unit with read-modify-write for SB/SH.
// Define LSU_ALIGN_CHECK_EN to report misaligned halfword/word accesses as errors.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    lsu_state_t  r_state, w_next;
    logic        r_we, r_resp_valid, r_resp_err;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_word, r_resp_rdata;
    logic        w_f3_ok, w_range_err, w_mis, w_err;
    logic [31:0] w_lane_word, w_load, w_store;

    always_comb begin
        w_f3_ok = req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
                  (!req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU));
        w_range_err = ({1'b0, req_addr} + 33'(acc_size(req_funct3))) > 33'(MEM_BYTES);
`ifdef LSU_ALIGN_CHECK_EN
        w_mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
        w_mis = 1'b0;
`endif
        w_err = !w_f3_ok || w_range_err || w_mis;
    end

    // SW skips the read; SB/SH must fetch the old word before merging
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = !req_valid ? IDLE : w_err ? RESP :
                           (req_we && req_funct3 == F3_W) ? WR : RD;
            RD:   w_next = r_we ? WR : RESP;
            WR:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    assign w_lane_word = r_state == RD ? mem_rd : r_word;

    lsu_byte_lane u_lane (
        .i_word (w_lane_word),
        .i_wdata(r_wdata),
        .i_off  (r_addr[1:0]),
        .i_f3   (r_f3),
        .o_load (w_load),
        .o_store(w_store)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_f3         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_word       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= w_next == RESP;
            r_resp_err   <= r_state == IDLE && req_valid && w_err;
            r_resp_rdata <= (r_state == RD && !r_we) ? w_load : '0;
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == RD) r_word <= mem_rd;
        end
    end

    always_comb begin
        req_ready  = r_state == IDLE;
        mem_read   = r_state == RD;
        mem_write  = r_state == WR;
        mem_addr   = (mem_read || mem_write) ? {r_addr[31:2], 2'b00} : '0;
        mem_wd     = mem_write ? w_store : '0;
        resp_valid = r_resp_valid;
        resp_err   = r_resp_err;
        resp_rdata = r_resp_rdata;
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed table-driven bench for mem_lsu with a word-wide memory model.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
    logic [31:0] mem [0:255] = '{default: 32'h0};
    int checks = 0, failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wd;
    assign mem_rd = mem[mem_addr[9:2]];

    mem_lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wd;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int lat, nrd, nwr;
        logic [31:0] wd;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0; wd = '0;
        while (!resp_valid && lat < 10) begin
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wd = mem_wd; end
            if (mem_read && mem_write) chk($sformatf("v%0d_both_strobes", idx), 32'd1, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_resp_valid", idx), 32'(resp_valid), 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
        chk($sformatf("v%0d_err", idx), 32'(resp_err), 32'(v.err));
        chk($sformatf("v%0d_reads", idx), 32'(nrd), 32'(v.nrd));
        chk($sformatf("v%0d_writes", idx), 32'(nwr), 32'(v.nwr));
        if (v.nwr > 0) chk($sformatf("v%0d_mem_wd", idx), wd, v.wd);
    endtask

    initial begin
        logic rdy [6];
        logic rv [6];
        logic [31:0] rd [6];
        int nwr, nresp;
        //        we    f3      addr          wdata          rdata          err  lat rd wr wd
        tv[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
        tv[1]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0};
        tv[2]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 0, 32'h0};
        tv[3]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h000000BE, 1'b0, 2, 1, 0, 32'h0};
        tv[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0, 32'h0};
        tv[5]  = '{1'b1, 3'b000, 32'h102, 32'h12345677, 32'h0,        1'b0, 3, 1, 1, 32'hDE77BEEF};
        tv[6]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFDE77, 1'b0, 2, 1, 0, 32'h0};
        tv[7]  = '{1'b0, 3'b010, 32'h3FE, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tv[8]  = '{1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tv[9]  = '{1'b1, 3'b011, 32'h0,   32'h1,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tv[10] = '{1'b1, 3'b001, 32'h3FC, 32'hAAAA5555, 32'h0,        1'b0, 3, 1, 1, 32'h00005555};
        tv[11] = '{1'b0, 3'b010, 32'h3FC, 32'h0,        32'h00005555, 1'b0, 2, 1, 0, 32'h0};
        tv[12] = '{1'b0, 3'b100, 32'h3FF, 32'h0,        32'h0,        1'b0, 2, 1, 0, 32'h0};
        tv[13] = '{1'b0, 3'b000, 32'h400, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tv[14] = '{1'b1, 3'b010, 32'h3FD, 32'h1,        32'h0,        1'b1, 1, 0, 0, 32'h0};
        tv[15] = '{1'b0, 3'b110, 32'h10,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
`ifdef LSU_ALIGN_CHECK_EN
        tv[16] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
`else
        tv[16] = '{1'b0, 3'b010, 32'h102, 32'h0,        32'hDE77BEEF, 1'b0, 2, 1, 0, 32'h0};
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);

        for (int i = 0; i < NV; i++) run(i, tv[i]);

        // reset while the SB read-modify-write is in its read phase
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h104; req_wdata = 32'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_rd", 32'(mem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nwr = 0; nresp = 0;
        repeat (4) begin
            @(negedge clk);
            nwr += int'(mem_write);
            nresp += int'(resp_valid);
        end
        chk("abort_writes", 32'(nwr), 32'd0);
        chk("abort_resp", 32'(nresp), 32'd0);
        chk("abort_mem_word", mem[65], 32'h0);
        chk("abort_idle_ready", 32'(req_ready), 32'd1);
        run(100, '{1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 1'b0, 2, 1, 0, 32'h0});

        // back-to-back loads with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            rdy[c] = req_ready; rv[c] = resp_valid; rd[c] = resp_rdata;
            if (c == 1) req_addr = 32'h3FC;
            if (c == 4) req_valid = 1'b0;
        end
        chk("b2b_ready", {26'b0, rdy[0], rdy[1], rdy[2], rdy[3], rdy[4], rdy[5]}, 32'b100100);
        chk("b2b_valid", {26'b0, rv[0], rv[1], rv[2], rv[3], rv[4], rv[5]}, 32'b001001);
        chk("b2b_data0", rd[2], 32'hDE77BEEF);
        chk("b2b_data1", rd[5], 32'h00005555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
